// File: rtl/data_stack.sv
// Register-based LIFO for the CSM core; optional sticky error check under `STACK_CHECK_EN.
// Latency: an op's effect on o_s0/o_s1/o_depth/o_err is visible the cycle after its edge.
// Backpressure: none; every i_se is accepted each cycle, overflow drops the bottom cell.
module data_stack #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 12,
  parameter int CWIDTH = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [2:0]        i_se,
  input  logic [WIDTH-1:0]  i_data,
  output logic [WIDTH-1:0]  o_s0,
  output logic [WIDTH-1:0]  o_s1,
  output logic [CWIDTH-1:0] o_depth,
  output logic              o_err
);

  localparam logic [2:0] SE_NONE  = 3'd0;
  localparam logic [2:0] SE_DROP  = 3'd1;
  localparam logic [2:0] SE_PUSH  = 3'd2;
  localparam logic [2:0] SE_RPLC  = 3'd3;
  localparam logic [2:0] SE_SWAP  = 3'd4;
  localparam logic [2:0] SE_DUP   = 3'd5;
  localparam logic [2:0] SE_OVER  = 3'd6;
  localparam logic [2:0] SE_RPLC2 = 3'd7;

  localparam logic [CWIDTH-1:0] FULL = CWIDTH'(DEPTH);
  localparam logic [CWIDTH-1:0] ONE  = CWIDTH'(1);

  logic [WIDTH-1:0]  cell_q [DEPTH];
  logic [WIDTH-1:0]  cell_d [DEPTH];
  logic [CWIDTH-1:0] depth_q, depth_d;
  logic              lt1, lt2, full;
  logic              do_push;
  logic [WIDTH-1:0]  push_val;

  assign lt1  = (depth_q == '0);
  assign lt2  = (depth_q < CWIDTH'(2));
  assign full = (depth_q == FULL);

  always_comb begin
    cell_d   = cell_q;
    depth_d  = depth_q;
    do_push  = 1'b0;
    push_val = i_data;
    case (i_se)
      SE_DROP: begin
        for (int n = 0; n < DEPTH - 1; n++) cell_d[n] = cell_q[n+1];
        cell_d[DEPTH-1] = '0;
        if (!lt1) depth_d = depth_q - ONE;
      end
      SE_PUSH: begin
        do_push  = 1'b1;
        push_val = i_data;
      end
      SE_RPLC: begin
        cell_d[0] = i_data;
        if (lt1) depth_d = ONE;
      end
      SE_SWAP: begin
        cell_d[0] = cell_q[1];
        cell_d[1] = cell_q[0];
      end
      SE_DUP: begin
        do_push  = 1'b1;
        push_val = cell_q[0];
      end
      SE_OVER: begin
        do_push  = 1'b1;
        push_val = cell_q[1];
      end
      SE_RPLC2: begin
        cell_d[0] = i_data;
        for (int n = 1; n < DEPTH - 1; n++) cell_d[n] = cell_q[n+1];
        cell_d[DEPTH-1] = '0;
        depth_d = lt2 ? ONE : depth_q - ONE;
      end
      default: ;
    endcase
    // All push-like ops share one shifter; the bottom cell falls off on overflow.
    if (do_push) begin
      for (int n = 1; n < DEPTH; n++) cell_d[n] = cell_q[n-1];
      cell_d[0] = push_val;
      if (!full) depth_d = depth_q + ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int n = 0; n < DEPTH; n++) cell_q[n] <= '0;
      depth_q <= '0;
    end else begin
      cell_q  <= cell_d;
      depth_q <= depth_d;
    end
  end

  assign o_s0    = cell_q[0];
  assign o_s1    = cell_q[1];
  assign o_depth = depth_q;

`ifdef STACK_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    case (i_se)
      SE_DROP, SE_RPLC:  if (lt1) err_d = 1'b1;
      SE_SWAP, SE_RPLC2: if (lt2) err_d = 1'b1;
      SE_PUSH:           if (full) err_d = 1'b1;
      SE_DUP:            if (lt1 || full) err_d = 1'b1;
      SE_OVER:           if (lt2 || full) err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_stack.sv
// Directed self-checking bench for data_stack (default parameters).
module tb_data_stack;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 12;
  localparam int CWIDTH = $clog2(DEPTH + 1);
`ifdef STACK_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  localparam logic [2:0] NONE = 3'd0, DROP = 3'd1, PUSH = 3'd2, RPLC = 3'd3,
                         SWAP = 3'd4, DUP  = 3'd5, OVER = 3'd6, RPLC2 = 3'd7;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [2:0]        i_se;
  logic [WIDTH-1:0]  i_data;
  logic [WIDTH-1:0]  o_s0, o_s1;
  logic [CWIDTH-1:0] o_depth;
  logic              o_err;

  int tests = 0;
  int fails = 0;

  data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_se(i_se), .i_data(i_data),
    .o_s0(o_s0), .o_s1(o_s1), .o_depth(o_depth), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  // Apply one op for one edge; outputs are sampled 1 time unit after that edge.
  task automatic step(input logic [2:0] se, input logic [WIDTH-1:0] d);
    i_se   = se;
    i_data = d;
    @(posedge i_clk);
    #1;
    i_se   = NONE;
    i_data = '0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step(NONE, 8'h00);
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (o_s0 !== 8'h00) begin fails++; $display("FAIL reset_s0 got %h want 00", o_s0); end
    tests++; if (o_s1 !== 8'h00) begin fails++; $display("FAIL reset_s1 got %h want 00", o_s1); end
    tests++; if (o_depth !== 4'd0) begin fails++; $display("FAIL reset_depth got %0d want 0", o_depth); end
    tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", o_err); end
  endtask

  task automatic test_push();
    do_reset();
    step(PUSH, 8'h11);
    step(PUSH, 8'h22);
    step(PUSH, 8'h33);
    tests++; if (o_s0 !== 8'h33) begin fails++; $display("FAIL push_s0 got %h want 33", o_s0); end
    tests++; if (o_s1 !== 8'h22) begin fails++; $display("FAIL push_s1 got %h want 22", o_s1); end
    tests++; if (o_depth !== 4'd3) begin fails++; $display("FAIL push_depth got %0d want 3", o_depth); end
    tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL push_err got %b want 0", o_err); end
  endtask

  // Continues from {0x33,0x22,0x11} left by test_push.
  task automatic test_swap_over_dup();
    step(SWAP, 8'h00);
    tests++; if (o_s0 !== 8'h22 || o_s1 !== 8'h33) begin fails++; $display("FAIL swap got s0=%h s1=%h want 22 33", o_s0, o_s1); end
    tests++; if (o_depth !== 4'd3) begin fails++; $display("FAIL swap_depth got %0d want 3", o_depth); end
    step(OVER, 8'h00);
    tests++; if (o_s0 !== 8'h33 || o_s1 !== 8'h22) begin fails++; $display("FAIL over got s0=%h s1=%h want 33 22", o_s0, o_s1); end
    tests++; if (o_depth !== 4'd4) begin fails++; $display("FAIL over_depth got %0d want 4", o_depth); end
    step(DUP, 8'h00);
    tests++; if (o_s0 !== 8'h33 || o_s1 !== 8'h33) begin fails++; $display("FAIL dup got s0=%h s1=%h want 33 33", o_s0, o_s1); end
    tests++; if (o_depth !== 4'd5) begin fails++; $display("FAIL dup_depth got %0d want 5", o_depth); end
    // Stack now 33,33,22,33,11: DROP exposes the element below.
    step(DROP, 8'h00);
    tests++; if (o_s0 !== 8'h33 || o_s1 !== 8'h22 || o_depth !== 4'd4) begin
      fails++; $display("FAIL drop got s0=%h s1=%h d=%0d want 33 22 4", o_s0, o_s1, o_depth); end
    tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL sod_err got %b want 0", o_err); end
  endtask

  task automatic test_alu_rplc2();
    do_reset();
    step(PUSH, 8'h03);
    step(PUSH, 8'h05);
    tests++; if (o_s0 !== 8'h05 || o_s1 !== 8'h03) begin fails++; $display("FAIL alu_args got s0=%h s1=%h want 05 03", o_s0, o_s1); end
    step(NONE, 8'h00);
    tests++; if (o_s0 !== 8'h05 || o_depth !== 4'd2) begin fails++; $display("FAIL alu_hold got s0=%h d=%0d want 05 2", o_s0, o_depth); end
    step(RPLC2, 8'h08);
    tests++; if (o_s0 !== 8'h08 || o_s1 !== 8'h00) begin fails++; $display("FAIL rplc2 got s0=%h s1=%h want 08 00", o_s0, o_s1); end
    tests++; if (o_depth !== 4'd1) begin fails++; $display("FAIL rplc2_depth got %0d want 1", o_depth); end
    step(RPLC, 8'h09);
    tests++; if (o_s0 !== 8'h09 || o_depth !== 4'd1) begin fails++; $display("FAIL rplc got s0=%h d=%0d want 09 1", o_s0, o_depth); end
    tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL alu_err got %b want 0", o_err); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 12; i++) step(PUSH, WIDTH'(i));
    tests++; if (o_depth !== 4'd12 || o_err !== 1'b0) begin fails++; $display("FAIL full got d=%0d err=%b want 12 0", o_depth, o_err); end
    step(PUSH, 8'd13);
    tests++; if (o_depth !== 4'd12) begin fails++; $display("FAIL ovf_depth got %0d want 12", o_depth); end
    tests++; if (o_s0 !== 8'd13 || o_s1 !== 8'd12) begin fails++; $display("FAIL ovf_top got s0=%0d s1=%0d want 13 12", o_s0, o_s1); end
    tests++; if (o_err !== CHK) begin fails++; $display("FAIL ovf_err got %b want %b", o_err, CHK); end
    for (int i = 0; i < 11; i++) step(DROP, 8'h00);
    tests++; if (o_s0 !== 8'd2 || o_s1 !== 8'd0 || o_depth !== 4'd1) begin
      fails++; $display("FAIL drain got s0=%0d s1=%0d d=%0d want 2 0 1", o_s0, o_s1, o_depth); end
    step(DROP, 8'h00);
    tests++; if (o_s0 !== 8'd0 || o_depth !== 4'd0) begin fails++; $display("FAIL lost got s0=%0d d=%0d want 0 0", o_s0, o_depth); end
    tests++; if (o_err !== CHK) begin fails++; $display("FAIL sticky_err got %b want %b", o_err, CHK); end
  endtask

  task automatic test_underflow();
    do_reset();
    step(DROP, 8'h00);
    tests++; if (o_depth !== 4'd0 || o_s0 !== 8'h00) begin fails++; $display("FAIL udf_drop got d=%0d s0=%h want 0 00", o_depth, o_s0); end
    tests++; if (o_err !== CHK) begin fails++; $display("FAIL udf_err got %b want %b", o_err, CHK); end
    do_reset();
    step(RPLC, 8'h44);
    tests++; if (o_depth !== 4'd1 || o_s0 !== 8'h44) begin fails++; $display("FAIL udf_rplc got d=%0d s0=%h want 1 44", o_depth, o_s0); end
    step(SWAP, 8'h00);
    tests++; if (o_depth !== 4'd1 || o_s0 !== 8'h00 || o_s1 !== 8'h44) begin
      fails++; $display("FAIL udf_swap got d=%0d s0=%h s1=%h want 1 00 44", o_depth, o_s0, o_s1); end
    step(RPLC2, 8'h55);
    tests++; if (o_depth !== 4'd1 || o_s0 !== 8'h55 || o_s1 !== 8'h00) begin
      fails++; $display("FAIL udf_rplc2 got d=%0d s0=%h s1=%h want 1 55 00", o_depth, o_s0, o_s1); end
    tests++; if (o_err !== CHK) begin fails++; $display("FAIL udf_err2 got %b want %b", o_err, CHK); end
  endtask

  task automatic test_reset_priority();
    do_reset();
    step(PUSH, 8'h77);
    step(DROP, 8'h00);
    step(DROP, 8'h00);
    i_rst = 1'b1;
    step(PUSH, 8'hAA);
    i_rst = 1'b0;
    tests++; if (o_depth !== 4'd0 || o_s0 !== 8'h00) begin fails++; $display("FAIL rstpri got d=%0d s0=%h want 0 00", o_depth, o_s0); end
    tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL rstpri_err got %b want 0", o_err); end
    for (int i = 0; i < 5; i++) begin
      step(NONE, 8'hFF);
      tests++; if (o_depth !== 4'd0 || o_s0 !== 8'h00 || o_s1 !== 8'h00 || o_err !== 1'b0) begin
        fails++; $display("FAIL idle%0d got d=%0d s0=%h s1=%h err=%b want 0 00 00 0", i, o_depth, o_s0, o_s1, o_err); end
    end
  endtask

  initial begin
    i_rst  = 1'b1;
    i_se   = NONE;
    i_data = '0;
    @(posedge i_clk);
    #1;
    test_reset();
    test_push();
    test_swap_over_dup();
    test_alu_rplc2();
    test_overflow();
    test_underflow();
    test_reset_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
